// File: rtl/keypad_pkg.sv
// Shared definitions for the front-panel keypad scanner.
// Contents: scanner FSM state type, matrix geometry, column reset pattern
// and a row priority helper (lowest-index pressed row wins).
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    // Column 0 is driven low out of reset.
    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } state_t;

    // Index of the lowest active-low row bit; row 0 has priority.
    // The result is only meaningful when at least one bit is low.
    function automatic logic [1:0] low_row_idx(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs (keypad rows,
// panel push buttons). Both stages reset to all ones, i.e. "not pressed"
// for active-low inputs.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   d_i  - asynchronous input bus
//   q_o  - synchronized output bus (two cycles of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press and release debounce.
// One column is driven low per dwell of SCAN_TICKS cycles; rows are sampled
// once per dwell (on tick). A candidate key freezes the column until it is
// either rejected, or accepted and later debounced as released.
// Ports:
//   clk       - system clock, all logic on the rising edge
//   rst       - synchronous active-high reset
//   rows_n    - keypad rows, active-low, asynchronous
//   col_n     - column drive, one-hot active-low
//   key_code  - last accepted key {row_idx, col_idx}
//   key_valid - one-cycle pulse per accepted press
//   key_held  - high from acceptance until debounced release
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] rows_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  DEB_N     = CNT_W'(DEBOUNCE_SCANS);

    logic [NUM_ROWS-1:0] rows_s;

    sync_2ff #(.WIDTH(NUM_ROWS)) u_rows_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rows_n),
        .q_o (rows_s)
    );

    // Dwell counter: free-running in every state.
    logic [TICK_W-1:0] tick_q;
    logic              tick;

    assign tick = (tick_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
        end else if (tick) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    state_t              state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [1:0]          cand_row_q, cand_row_d;
    logic [CNT_W-1:0]    match_q, match_d;
    logic [CNT_W-1:0]    rel_q, rel_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                held_q, held_d;

    logic                hit;
    logic [1:0]          row_idx;
    logic [CNT_W-1:0]    match_inc;
    logic [CNT_W-1:0]    rel_inc;

    assign hit       = ~&rows_s;
    assign row_idx   = low_row_idx(rows_s);
    assign match_inc = match_q + CNT_W'(1);
    assign rel_inc   = rel_q + CNT_W'(1);

    // The column index is frozen outside SCAN, so it doubles as the
    // latched candidate column; no separate cand_col register is needed.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cand_row_d = cand_row_q;
        match_d    = match_q;
        rel_d      = rel_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        held_d     = held_q;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        cand_row_d = row_idx;
                        match_d    = CNT_W'(1);
                        state_d    = CONFIRM;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                CONFIRM: begin
                    if (!rows_s[cand_row_q]) begin
                        match_d = match_inc;
                        if (match_inc == DEB_N) begin
                            code_d  = {cand_row_q, col_idx_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            rel_d   = '0;
                            state_d = HELD;
                        end
                    end else begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                HELD: begin
                    // Only the accepted row is watched; other keys in
                    // this column are deliberately ignored.
                    if (rows_s[cand_row_q]) begin
                        rel_d = rel_inc;
                        if (rel_inc == DEB_N) begin
                            held_d    = 1'b0;
                            rel_d     = '0;
                            state_d   = SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
    end

    // Registered one-hot-low column drive derived from the next index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign col_n_d[gi] = (col_idx_d != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            col_idx_q  <= 2'd0;
            col_n_q    <= COL_RESET;
            cand_row_q <= 2'd0;
            match_q    <= '0;
            rel_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            col_n_q    <= col_n_d;
            cand_row_q <= cand_row_d;
            match_q    <= match_d;
            rel_q      <= rel_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_TICKS=4, DEBOUNCE_SCANS=3).
// A physical keypad model turns a 16-bit "pressed" map plus the driven
// column into rows_n; a behavioural reference predicts every output.
module tb_keypad_scanner;

    localparam int ST = 4;
    localparam int DB = 3;

    // Reference model activity phases.
    localparam int LOOKING   = 0;
    localparam int VERIFYING = 1;
    localparam int LOCKED    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rows_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rows_n    (rows_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] pressed;   // bit r*4+c: key at row r, column c is down
    int          pulses;
    logic [3:0]  last_code;

    // Reference model state
    logic [3:0] m_s1, m_s2;
    int         m_cnt, m_mode, m_col, m_row, m_hits, m_rel;
    logic [3:0] m_code;
    logic       m_valid, m_held;

    typedef struct {
        int         row;
        int         col;
        logic [7:0] pat;       // bit i: key down during dwell window i
        int         nwin;
        int         exp_pulses;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [3:0] keypad_rows(input logic [15:0] p, input logic [3:0] cn);
        logic [3:0] rr;
        rr = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (p[r*4+c] && cn[c] == 1'b0) rr[r] = 1'b0;
        return rr;
    endfunction

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] v;
        v = 4'hF;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [3:0] rn);
        logic [3:0] rs;
        logic       tk;
        int         hr;
        if (r) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_cnt = 0; m_mode = LOOKING; m_col = 0;
            m_row = 0; m_hits = 0; m_rel = 0; m_code = 4'h0; m_valid = 0; m_held = 0;
            return;
        end
        rs = m_s2;
        tk = (m_cnt == ST - 1);
        m_cnt = (m_cnt + 1) % ST;
        m_s2 = m_s1;
        m_s1 = rn;
        m_valid = 1'b0;
        if (!tk) return;
        if (m_mode == LOOKING) begin
            hr = -1;
            for (int k = 3; k >= 0; k--) if (!rs[k]) hr = k;
            if (hr >= 0) begin
                m_row = hr; m_hits = 1; m_mode = VERIFYING;
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (m_mode == VERIFYING) begin
            if (!rs[m_row]) begin
                m_hits++;
                if (m_hits == DB) begin
                    m_code = 4'(m_row * 4 + m_col);
                    m_valid = 1'b1; m_held = 1'b1; m_rel = 0; m_mode = LOCKED;
                end
            end else begin
                m_mode = LOOKING; m_col = (m_col + 1) % 4;
            end
        end else begin
            if (rs[m_row]) begin
                m_rel++;
                if (m_rel == DB) begin
                    m_held = 1'b0; m_rel = 0; m_mode = LOOKING; m_col = (m_col + 1) % 4;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    task automatic step(input logic r);
        rst = r;
        rows_n = keypad_rows(pressed, col_n);
        @(posedge clk);
        model_update(r, rows_n);
        #1;
        check("col_n", col_n, col_pat(m_col));
        check("key_code", key_code, m_code);
        check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        check("key_held", {3'b0, key_held}, {3'b0, m_held});
        if (key_valid === 1'b1) begin
            pulses++;
            last_code = key_code;
        end
    endtask

    // Waits until a dwell of column c is about to start in LOOKING phase.
    task automatic wait_aligned(input int c);
        int n;
        n = 0;
        while (!(m_mode == LOOKING && m_col == c && m_cnt == 0) && n < 100) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL align_col%0d: got timeout expected column dwell start", c);
        end
    endtask

    task automatic window(input logic [15:0] map);
        pressed = map;
        repeat (ST) step(1'b0);
    endtask

    initial begin
        pressed = '0;
        rows_n  = 4'hF;
        rst     = 1'b1;
        pulses  = 0;
        last_code = 4'h0;

        vecs[0] = '{row: 2, col: 1, pat: 8'b0011_1111, nwin: 6, exp_pulses: 1, exp_code: 4'h9};
        vecs[1] = '{row: 2, col: 1, pat: 8'b0000_0101, nwin: 4, exp_pulses: 0, exp_code: 4'h9};
        vecs[2] = '{row: 0, col: 3, pat: 8'b0000_0111, nwin: 3, exp_pulses: 1, exp_code: 4'h3};
        vecs[3] = '{row: 3, col: 0, pat: 8'b0000_0011, nwin: 3, exp_pulses: 0, exp_code: 4'h3};
        vecs[4] = '{row: 1, col: 2, pat: 8'b0000_1111, nwin: 4, exp_pulses: 1, exp_code: 4'h6};
        vecs[5] = '{row: 3, col: 3, pat: 8'b0000_1101, nwin: 4, exp_pulses: 0, exp_code: 4'h6};

        // Reset and idle scan
        step(1'b1);
        step(1'b1);
        check("rst_col", col_n, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'h0);
        check("rst_held", {3'b0, key_held}, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0);
            if (k % 4 == 0) check("idle_col", col_n, col_pat((k / 4) % 4));
        end
        check("idle_pulses", 4'(pulses), 4'h0);

        // Table-driven press patterns
        for (int v = 0; v < 6; v++) begin
            wait_aligned(vecs[v].col);
            pulses = 0;
            for (int w = 0; w < vecs[v].nwin; w++)
                window(vecs[v].pat[w] ? (16'h1 << (vecs[v].row * 4 + vecs[v].col)) : 16'h0);
            window(16'h0);
            repeat (40) step(1'b0);
            check("vec_pulses", 4'(pulses), 4'(vecs[v].exp_pulses));
            check("vec_code", key_code, vecs[v].exp_code);
        end

        // Release debounce: high/low twice, then high
        wait_aligned(1);
        repeat (3) window(16'h1 << 9);
        check("rel_acc_code", key_code, 4'h9);
        check("rel_acc_held", {3'b0, key_held}, 4'h1);
        window(16'h0); window(16'h1 << 9);
        window(16'h0); window(16'h1 << 9);
        window(16'h0); window(16'h0);
        check("rel_still_held", {3'b0, key_held}, 4'h1);
        check("rel_frozen_col", col_n, 4'b1101);
        window(16'h0);
        check("rel_dropped", {3'b0, key_held}, 4'h0);
        check("rel_next_col", col_n, 4'b1011);

        // Simultaneous keys in column 0: rows 1 and 3
        wait_aligned(0);
        repeat (3) window((16'h1 << 4) | (16'h1 << 12));
        check("simul_code", key_code, 4'h4);
        pulses = 0;
        pressed = 16'h1 << 12;
        repeat (80) step(1'b0);
        check("simul_second_pulses", 4'(pulses), 4'h1);
        check("simul_second_code", last_code, 4'hC);
        pressed = '0;
        repeat (30) step(1'b0);

        // Reset while held, key still down
        wait_aligned(3);
        repeat (3) window(16'h1 << 11);
        check("mid_held", {3'b0, key_held}, 4'h1);
        step(1'b1);
        check("mid_rst_col", col_n, 4'b1110);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_valid", {3'b0, key_valid}, 4'h0);
        check("mid_rst_held", {3'b0, key_held}, 4'h0);
        pulses = 0;
        for (int n = 0; n < 100 && pulses == 0; n++) step(1'b0);
        check("mid_rereport_pulses", 4'(pulses), 4'h1);
        check("mid_rereport_code", last_code, 4'hB);
        pressed = '0;
        repeat (30) step(1'b0);

        // Randomized presses against the reference model
        for (int s = 0; s < 60; s++) begin
            int sel;
            int dur;
            sel = $urandom_range(0, 3);
            dur = $urandom_range(1, 60);
            if (sel == 0) pressed = '0;
            else if (sel == 3) pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            else pressed = 16'h1 << $urandom_range(0, 15);
            repeat (dur) step(1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
